uart_tx_serializer: RTL
=======================

Name: uart_tx_serializer

Overview:
- Downstream neighbour of the TX buffer FIFO in the UART_APB transmit path.
- Pops one byte from the FIFO over a valid/ready handshake and serialises it onto the UART TX line: start bit, DATA_WIDTH data bits LSB first, optional parity, then stop bit(s).
- Generates its own bit timing from the system clock with an internal divider.

Parameters:
- DATA_WIDTH, 8, data bits per frame; must match the FIFO data width.
- CLK_DIV, 16, clk cycles per UART bit; legal values >= 2.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
- PARITY_ODD, 0, 1 = odd parity, 0 = even parity; used only with UART_TX_PARITY_EN.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rstn  input  1  asynchronous active-low reset.
- data_i  input  DATA_WIDTH  byte from the FIFO (FIFO registered read data).
- valid_in  input  1  FIFO has data (FIFO valid_out).
- ready_in  output  1  serializer accepts a pop (drives FIFO ready_out).
- tx_o  output  1  UART serial line; idle high.
- busy_o  output  1  high in any state other than IDLE.
- done_o  output  1  one-cycle pulse when a frame's last stop bit completes.

Behaviour:
- Reset values: state IDLE, tx_o=1, busy_o=0, done_o=0, all counters 0, shift register 0. Reset acts immediately (asynchronous). ready_in=1 while in reset, because it decodes IDLE.
- States: IDLE, LOAD, START, DATA, PARITY (only with the macro), STOP.
- ready_in = (state==IDLE); purely combinational from state.
- Handshake: valid_in & ready_in sampled at clock edge E0.
  - IDLE -> LOAD at E0.
  - The FIFO updates its registered data_i at E0, so data_i is captured into the shift register at E1, the end of LOAD. It is never captured at E0.
- LOAD -> START at E1; tx_o=0 from E1.
- Baud counter:
  - Counts 0..CLK_DIV-1 within each bit.
  - Bit ends when the count reaches CLK_DIV-1; the counter then resets to 0.
  - Every bit is exactly CLK_DIV cycles.
- START -> DATA after one bit. DATA drives shift_reg[0] and shifts right at each bit end.
- Bit counter: counts 0..DATA_WIDTH-1; DATA exits after bit DATA_WIDTH-1.
- DATA -> PARITY (macro defined) or STOP.
- STOP: tx_o=1 for STOP_BITS*CLK_DIV cycles, then -> IDLE with done_o=1 for that single cycle.
- Frame timing:
  - Total bits N = 1 + DATA_WIDTH + P + STOP_BITS.
  - Return to IDLE at edge E1 + N*CLK_DIV.
  - Earliest next handshake edge is E1 + N*CLK_DIV + 1.
  - Minimum idle-high gap between frames is 2 cycles (IDLE + LOAD).
- valid_in changes while busy are ignored; no pop occurs outside IDLE.
- valid_in low in IDLE: remain idle with tx_o=1.
- Reset mid-frame: line returns high immediately; no done_o; the partial frame is lost. The FIFO entry already popped is not recovered.
- tx_o is driven from a flop; no combinational path from data_i to tx_o.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state inserted between DATA and STOP, one bit long.
  - Parity bit = ^data (the byte captured in LOAD) XOR PARITY_ODD; computed at LOAD capture.
  - N includes P=1.
- Undefined:
  - No PARITY state, no parity logic; P=0.
  - PARITY_ODD has no effect.

Decomposition:
- Shared package uart_pkg holds:
  - the state encoding typedef (tx_state_t);
  - a frame-bit-count function of DATA_WIDTH, STOP_BITS and parity enable;
  - the default CLK_DIV constant, shared with the RX side.
- One sub-module, uart_baud_tick:
  - counter of width $clog2(CLK_DIV);
  - inputs: enable and a sync clear;
  - outputs: a bit_end pulse.
- Everything else (FSM, shift register, bit counter) lives in uart_tx_serializer.

Test Plan:
- Single frame, CLK_DIV=4, no parity, data 8'hA5, handshake at E0:
  - tx_o reads 0,1,0,1,0,0,1,0,1,1, each held 4 cycles, starting at E1;
  - done_o pulses at E1+40.
- Parity, data 8'hA5 (four ones): PARITY_ODD=0 -> parity bit 0; PARITY_ODD=1 -> parity bit 1. Frame is 44 cycles.
- Back-to-back, FIFO holding 8'h00 then 8'hFF:
  - ready_in low throughout frame 1;
  - second handshake exactly one cycle after done_o;
  - tx_o high for exactly 2 cycles between the stop bit and the next start bit;
  - second frame's data bits all 1.
- Data-latency check: FIFO data changes only at the handshake edge; serialized byte equals the FIFO entry popped, not the previous registered value.
- STOP_BITS=2: stop segment 8 cycles at CLK_DIV=4; done_o at E1+44 without parity.
- Reset asserted during DATA bit 3:
  - tx_o=1, busy_o=0, ready_in=1 immediately; no done_o;
  - after release, the next handshake yields a clean full frame.

Source files
------------

// File: rtl/uart_tx_serializer_pkg.sv
// Shared UART definitions: TX state encoding, frame-length helper, default bit divider.
// Optional macro UART_TX_PARITY_EN adds the PARITY state to tx_state_t.
package uart_pkg;

  localparam int unsigned UART_CLK_DIV_DEFAULT = 16;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, PARITY, STOP} tx_state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} tx_state_t;
`endif

  function automatic int unsigned frame_bits(int unsigned data_width,
                                             int unsigned stop_bits,
                                             bit          parity_en);
    return 1 + data_width + 32'(parity_en) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_tx_serializer_baud.sv
// Bit-period divider: counts 0..CLK_DIV-1 while enabled, bit_end flags the last count.
module uart_baud_tick #(
  parameter int unsigned CLK_DIV = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  input  logic clr,
  output logic bit_end
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign bit_end = en && (cnt == LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= bit_end ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops a byte from the TX FIFO and shifts out start/data/stop bits.
// Optional macro UART_TX_PARITY_EN inserts a parity bit between data and stop.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CLK_DIV    = UART_CLK_DIV_DEFAULT,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_in,
  output logic                  ready_in,
  output logic                  tx_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int unsigned BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  if (CLK_DIV < 2 || STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD > 1) begin : g_param_check
    $error("uart_tx_serializer: illegal parameter value");
  end

  tx_state_t             state, state_nxt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] shifted;
  logic [BW-1:0]         bit_cnt;
  logic                  tx_nxt;
  logic                  bit_end;
  logic                  baud_en;
  logic                  last_data;
  logic                  last_stop;
`ifdef UART_TX_PARITY_EN
  logic                  parity_bit;
`endif

  assign ready_in  = (state == IDLE);
  assign busy_o    = (state != IDLE);
  assign baud_en   = (state != IDLE) && (state != LOAD);
  assign shifted   = shift_reg >> 1;
  assign last_data = (bit_cnt == BW'(DATA_WIDTH - 1));
  assign last_stop = (bit_cnt == BW'(STOP_BITS - 1));

  uart_baud_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_baud (
    .clk     (clk),
    .rstn    (rstn),
    .en      (baud_en),
    .clr     (!baud_en),
    .bit_end (bit_end)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (valid_in) state_nxt = LOAD;
      LOAD:   state_nxt = START;
      START:  if (bit_end) state_nxt = DATA;
`ifdef UART_TX_PARITY_EN
      DATA:   if (bit_end && last_data) state_nxt = PARITY;
      PARITY: if (bit_end) state_nxt = STOP;
`else
      DATA:   if (bit_end && last_data) state_nxt = STOP;
`endif
      STOP:   if (bit_end && last_stop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // tx_o is registered: the line value is chosen from the state being entered,
  // and a DATA->DATA bit boundary presents the bit the shift is about to expose.
  always_comb begin
    tx_nxt = 1'b1;
    case (state_nxt)
      START:  tx_nxt = 1'b0;
      DATA:   tx_nxt = (state == DATA && bit_end) ? shifted[0] : shift_reg[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_nxt = parity_bit;
`endif
      default: tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      tx_o      <= 1'b1;
      done_o    <= 1'b0;
      shift_reg <= '0;
      bit_cnt   <= '0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      tx_o   <= tx_nxt;
      done_o <= (state == STOP) && (state_nxt == IDLE);

      // data_i only holds the popped entry one cycle after the handshake
      if (state == LOAD) begin
        shift_reg <= data_i;
`ifdef UART_TX_PARITY_EN
        parity_bit <= (^data_i) ^ 1'(PARITY_ODD);
`endif
      end else if (state == DATA && bit_end) begin
        shift_reg <= shifted;
      end

      if (bit_end && (state == DATA || state == STOP)) begin
        bit_cnt <= (state_nxt != state) ? '0 : bit_cnt + BW'(1);
      end
    end
  end

endmodule
